// File: rtl/ceespu_arb_pkg.sv
// Shared types and constants for the ceespu memory arbiter.
package ceespu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2,
        DONE = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_D = 1'b0,
        OWN_I = 1'b1
    } arb_owner_e;

    localparam int STARVE_W = 4;

    // Increment the fetch-starvation count, holding at the limit.
    function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt,
                                                       input logic [STARVE_W-1:0] lim);
        return (cnt >= lim) ? lim : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/ceespu_arb_fetch_buf.sv
// One-entry fetch buffer: remembers the last fetched word by word address.
// Only instantiated when CEESPU_ARB_FETCH_BUFFER_EN is defined.
module ceespu_arb_fetch_buf #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-3:0] lookup_tag,
    output logic              hit,
    output logic [31:0]       hit_data,
    input  logic              fill,
    input  logic [ADDR_W-3:0] fill_tag,
    input  logic [31:0]       fill_data,
    input  logic              inv,
    input  logic [ADDR_W-3:0] inv_tag
);

    logic              valid_q, valid_d;
    logic [ADDR_W-3:0] tag_q, tag_d;
    logic [31:0]       word_q, word_d;

    // Next-state of the entry: a fill wins, a matching store kills the entry.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        word_d  = word_q;
        if (fill) begin
            valid_d = 1'b1;
            tag_d   = fill_tag;
            word_d  = fill_data;
        end else if (inv && (inv_tag == tag_q)) begin
            valid_d = 1'b0;
        end
    end

    // Valid bit is the only state that must be cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) valid_q <= 1'b0;
        else     valid_q <= valid_d;
    end

    // Tag and word are meaningless while invalid, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        word_q <= word_d;
    end

    assign hit      = valid_q && (tag_q == lookup_tag);
    assign hit_data = word_q;

endmodule

// File: rtl/ceespu_mem_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch and data
// access. Data wins unless fetch has been starved STARVE_LIMIT times in a row.
// Optional macro CEESPU_ARB_FETCH_BUFFER_EN adds a one-entry fetch buffer.
module ceespu_mem_arbiter
    import ceespu_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 16
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_ifEnable,
    input  logic [ADDR_W-1:0] I_ifAddress,
    output logic [31:0]       O_ifData,
    output logic              O_ifBusy,
    input  logic              I_dEnable,
    input  logic [3:0]        I_dWe,
    input  logic [ADDR_W-1:0] I_dAddress,
    input  logic [31:0]       I_dWData,
    output logic [31:0]       O_dData,
    output logic              O_dBusy,
    output logic              O_memE,
    output logic [3:0]        O_memWe,
    output logic [ADDR_W-1:0] O_memAddress,
    output logic [31:0]       O_memWData,
    input  logic [31:0]       I_memData,
    input  logic              I_memReady
);

    localparam logic [STARVE_W-1:0] LIMIT     = STARVE_W'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0]   WORD_MASK = ~ADDR_W'(3);

    arb_state_e           state_q, state_d;
    arb_owner_e           owner_q, owner_d;
    logic [STARVE_W-1:0]  starve_q, starve_d;
    logic                 mem_e_q, mem_e_d;
    logic [3:0]           mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic [31:0]          mem_wdata_q, mem_wdata_d;
    logic [31:0]          if_data_q, if_data_d;
    logic [31:0]          d_data_q, d_data_d;
    logic                 d_win;
    logic                 buf_hit;
    logic [31:0]          buf_data;

`ifdef CEESPU_ARB_FETCH_BUFFER_EN
    ceespu_arb_fetch_buf #(
        .ADDR_W (ADDR_W)
    ) u_fetch_buf (
        .clk        (I_clk),
        .rst        (I_rst),
        .lookup_tag (I_ifAddress[ADDR_W-1:2]),
        .hit        (buf_hit),
        .hit_data   (buf_data),
        .fill       ((state_q == IACC) && I_memReady),
        .fill_tag   (mem_addr_q[ADDR_W-1:2]),
        .fill_data  (I_memData),
        .inv        ((state_q == DACC) && I_memReady && (mem_we_q != 4'b0)),
        .inv_tag    (mem_addr_q[ADDR_W-1:2])
    );
`else
    assign buf_hit  = 1'b0;
    assign buf_data = 32'b0;
`endif

    // Arbitration and bus sequencing: IDLE grants, xACC waits for ready,
    // DONE gives the requester one cycle to drop or change its request.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        mem_e_d     = mem_e_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_data_d   = if_data_q;
        d_data_d    = d_data_q;
        d_win       = I_dEnable && (!I_ifEnable || (starve_q < LIMIT));

        case (state_q)
            IDLE: begin
                if (d_win) begin
                    state_d     = DACC;
                    owner_d     = OWN_D;
                    mem_e_d     = 1'b1;
                    mem_we_d    = I_dWe;
                    mem_addr_d  = I_dAddress;
                    mem_wdata_d = I_dWData;
                    starve_d    = I_ifEnable ? starve_inc(starve_q, LIMIT) : '0;
                end else if (I_ifEnable) begin
                    owner_d  = OWN_I;
                    starve_d = '0;
                    if (buf_hit) begin
                        state_d   = DONE;
                        if_data_d = buf_data;
                    end else begin
                        state_d    = IACC;
                        mem_e_d    = 1'b1;
                        mem_we_d   = 4'b0;
                        mem_addr_d = I_ifAddress & WORD_MASK;
                    end
                end
            end
            DACC, IACC: begin
                if (I_memReady) begin
                    state_d  = DONE;
                    mem_e_d  = 1'b0;
                    mem_we_d = 4'b0;
                    if (state_q == IACC)
                        if_data_d = I_memData;
                    else if (mem_we_q == 4'b0)
                        d_data_d = I_memData;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // All arbiter state and bus outputs, cleared immediately on reset.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_D;
            starve_q    <= '0;
            mem_e_q     <= 1'b0;
            mem_we_q    <= 4'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'b0;
            if_data_q   <= 32'b0;
            d_data_q    <= 32'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            mem_e_q     <= mem_e_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_data_q   <= if_data_d;
            d_data_q    <= d_data_d;
        end
    end

    assign O_memE       = mem_e_q;
    assign O_memWe      = mem_we_q;
    assign O_memAddress = mem_addr_q;
    assign O_memWData   = mem_wdata_q;
    assign O_ifData     = if_data_q;
    assign O_dData      = d_data_q;
    assign O_dBusy      = I_dEnable  & ~((state_q == DONE) && (owner_q == OWN_D));
    assign O_ifBusy     = I_ifEnable & ~((state_q == DONE) && (owner_q == OWN_I));

endmodule

// File: tb/tb_ceespu_mem_arbiter.sv
// Testbench for ceespu_mem_arbiter: transaction-level reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_ceespu_mem_arbiter;

    localparam int LIMIT = 4;
`ifdef CEESPU_ARB_FETCH_BUFFER_EN
    localparam bit HAS_BUF = 1'b1;
`else
    localparam bit HAS_BUF = 1'b0;
`endif
    localparam int PH_FREE = 0, PH_BUSY = 1, PH_HAND = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifEn;
    logic [15:0] ifAddr;
    logic [31:0] O_ifData;
    logic        O_ifBusy;
    logic        dEn;
    logic [3:0]  dWe;
    logic [15:0] dAddr;
    logic [31:0] dWData;
    logic [31:0] O_dData;
    logic        O_dBusy;
    logic        O_memE;
    logic [3:0]  O_memWe;
    logic [15:0] O_memAddress;
    logic [31:0] O_memWData;
    logic [31:0] I_memData;
    logic        I_memReady;

    int total = 0;
    int bad   = 0;

    ceespu_mem_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(16)) dut (
        .I_clk        (clk),
        .I_rst        (rst),
        .I_ifEnable   (ifEn),
        .I_ifAddress  (ifAddr),
        .O_ifData     (O_ifData),
        .O_ifBusy     (O_ifBusy),
        .I_dEnable    (dEn),
        .I_dWe        (dWe),
        .I_dAddress   (dAddr),
        .I_dWData     (dWData),
        .O_dData      (O_dData),
        .O_dBusy      (O_dBusy),
        .O_memE       (O_memE),
        .O_memWe      (O_memWe),
        .O_memAddress (O_memAddress),
        .O_memWData   (O_memWData),
        .I_memData    (I_memData),
        .I_memReady   (I_memReady)
    );

    always #5 clk = ~clk;

    // Memory responder: word array, ready after mem_wait wait cycles.
    logic [31:0] mem [0:255];
    int unsigned mem_wait;
    int unsigned wcnt;
    assign I_memReady = O_memE && (wcnt >= mem_wait);
    assign I_memData  = mem[O_memAddress[9:2]];
    always @(posedge clk or posedge rst) begin
        if (rst)                        wcnt <= 0;
        else if (O_memE && !I_memReady) wcnt <= wcnt + 1;
        else                            wcnt <= 0;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the bus is free, carrying one transaction, or in
    // its one-cycle handoff to the requester.
    int          m_ph;
    bit          m_isd;
    int          m_starve;
    bit          m_memE;
    logic [3:0]  m_we;
    logic [15:0] m_addr;
    logic [31:0] m_wdata, m_if, m_d;
    bit          b_valid;
    logic [13:0] b_tag;
    logic [31:0] b_word;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= PH_FREE; m_isd <= 1'b1; m_starve <= 0; m_memE <= 1'b0;
            m_we <= 4'b0; m_addr <= 16'h0; m_wdata <= 32'h0; m_if <= 32'h0;
            m_d <= 32'h0; b_valid <= 1'b0;
        end else begin
            case (m_ph)
                PH_FREE: begin
                    if (dEn && (!ifEn || m_starve < LIMIT)) begin
                        m_ph <= PH_BUSY; m_isd <= 1'b1; m_memE <= 1'b1;
                        m_we <= dWe; m_addr <= dAddr; m_wdata <= dWData;
                        m_starve <= ifEn ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
                    end else if (ifEn) begin
                        m_isd <= 1'b0; m_starve <= 0;
                        if (HAS_BUF && b_valid && b_tag == ifAddr[15:2]) begin
                            m_ph <= PH_HAND; m_if <= b_word;
                        end else begin
                            m_ph <= PH_BUSY; m_memE <= 1'b1; m_we <= 4'b0;
                            m_addr <= {ifAddr[15:2], 2'b00};
                        end
                    end
                end
                PH_BUSY: begin
                    if (I_memReady) begin
                        m_ph <= PH_HAND; m_memE <= 1'b0; m_we <= 4'b0;
                        if (!m_isd) begin
                            m_if <= mem[m_addr[9:2]];
                            b_valid <= 1'b1; b_tag <= m_addr[15:2]; b_word <= mem[m_addr[9:2]];
                        end else if (m_we == 4'b0) begin
                            m_d <= mem[m_addr[9:2]];
                        end else if (b_tag == m_addr[15:2]) begin
                            b_valid <= 1'b0;
                        end
                    end
                end
                default: m_ph <= PH_FREE;
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("memE",   32'(O_memE),       32'(m_memE));
        chk("memWe",  32'(O_memWe),      32'(m_we));
        chk("memAddr",32'(O_memAddress), 32'(m_addr));
        chk("memWData", O_memWData,      m_wdata);
        chk("ifData", O_ifData,          m_if);
        chk("dData",  O_dData,           m_d);
        chk("dBusy",  32'(O_dBusy),  32'(dEn  && !(m_ph == PH_HAND &&  m_isd)));
        chk("ifBusy", 32'(O_ifBusy), 32'(ifEn && !(m_ph == PH_HAND && !m_isd)));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic data_op(input logic [3:0] we, input logic [15:0] a, input logic [31:0] wd,
                           input int unsigned wt, output int n, output int ecnt,
                           output logic [3:0] we_or, output logic [15:0] seen_addr);
        mem_wait = wt; dEn = 1'b1; dWe = we; dAddr = a; dWData = wd;
        n = 0; ecnt = 0; we_or = 4'b0; seen_addr = 16'h0;
        do begin
            cyc(); n++;
            if (O_memE) begin ecnt++; seen_addr = O_memAddress; end
            we_or |= O_memWe;
        end while (O_dBusy && n < 60);
        chk("d_busy_fell", 32'(O_dBusy), 32'd0);
        dEn = 1'b0; dWe = 4'b0;
        cyc();
    endtask

    task automatic fetch_op(input logic [15:0] a, input int unsigned wt, output int n,
                            output int ecnt, output logic [15:0] seen_addr);
        mem_wait = wt; ifEn = 1'b1; ifAddr = a; n = 0; ecnt = 0; seen_addr = 16'h0;
        do begin
            cyc(); n++;
            if (O_memE) begin ecnt++; seen_addr = O_memAddress; end
        end while (O_ifBusy && n < 60);
        chk("if_busy_fell", 32'(O_ifBusy), 32'd0);
        ifEn = 1'b0;
        cyc();
    endtask

    initial begin
        int n, ecnt, ng, run, maxrun;
        logic [3:0]  we_or;
        logic [15:0] sa;
        bit prevE;
        bit grants [0:9];
        bit exp_g [0:9];
        exp_g = '{1,1,1,1,0,1,1,1,1,0};
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | 32'(i);
        mem[4] = 32'hDEADBEEF;
        rst = 1'b1; ifEn = 1'b0; ifAddr = 16'h0; dEn = 1'b0; dWe = 4'b0;
        dAddr = 16'h0; dWData = 32'h0; mem_wait = 0;
        repeat (2) cyc();
        chk("rst_memE",  32'(O_memE), 32'd0);
        chk("rst_addr",  32'(O_memAddress), 32'd0);
        chk("rst_dData", O_dData, 32'd0);
        chk("rst_ifData", O_ifData, 32'd0);
        @(negedge clk); rst = 1'b0;
        cyc();

        // Read 0x0010 with two wait cycles.
        data_op(4'b0, 16'h0010, 32'h0, 2, n, ecnt, we_or, sa);
        chk("rd_latency", 32'(n), 32'd4);
        chk("rd_memE_cycles", 32'(ecnt), 32'd3);
        chk("rd_we", 32'(we_or), 32'd0);
        chk("rd_data", O_dData, 32'hDEADBEEF);

        // Zero-wait store leaves load data alone.
        data_op(4'b0011, 16'h0024, 32'h12345678, 0, n, ecnt, we_or, sa);
        chk("st_latency", 32'(n), 32'd2);
        chk("st_memE_cycles", 32'(ecnt), 32'd1);
        chk("st_we", 32'(we_or), 32'h3);
        chk("st_addr", 32'(sa), 32'h0024);
        chk("st_dData_kept", O_dData, 32'hDEADBEEF);

        // Fetch ignores the low two address bits.
        fetch_op(16'h0101, 0, n, ecnt, sa);
        chk("f_addr", 32'(sa), 32'h0100);
        chk("f_latency", 32'(n), 32'd2);
        chk("f_data", O_ifData, 32'hC0DE0040);

        // Data requester drops enable mid-access; access still completes.
        mem_wait = 1; dEn = 1'b1; dWe = 4'b0; dAddr = 16'h0008;
        cyc(); dEn = 1'b0;
        repeat (5) cyc();
        chk("drop_dData", O_dData, 32'hC0DE0002);
        chk("drop_memE", 32'(O_memE), 32'd0);

        // Both requests held: four data grants, then one fetch, repeating.
        mem_wait = 0; dEn = 1'b1; dWe = 4'b0; dAddr = 16'h0030; ifEn = 1'b1; ifAddr = 16'h0200;
        ng = 0; prevE = 1'b0; run = 0; maxrun = 0;
        for (int c = 0; c < 80 && ng < 10; c++) begin
            cyc();
            if (O_memE && !prevE) begin grants[ng] = (O_memAddress == 16'h0030); ng++; end
            prevE = O_memE;
            if (O_ifBusy) run++;
            else begin
                if (run > maxrun) maxrun = run;
                run = 0; ifAddr = ifAddr + 16'd4;
            end
        end
        chk("starve_ngrants", 32'(ng), 32'd10);
        for (int i = 0; i < 10; i++) chk($sformatf("grant%0d", i), 32'(grants[i]), 32'(exp_g[i]));
        chk("if_busy_max_le15", 32'(maxrun <= 15), 32'd1);
        dEn = 1'b0;
        n = 0;
        while (O_ifBusy && n < 20) begin cyc(); n++; end
        chk("starve_end", 32'(O_ifBusy), 32'd0);
        ifEn = 1'b0;
        repeat (2) cyc();

        // Asynchronous reset while a fetch waits on memory.
        mem_wait = 100; ifEn = 1'b1; ifAddr = 16'h0080;
        cyc(); cyc();
        chk("pre_rst_memE", 32'(O_memE), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_memE", 32'(O_memE), 32'd0);
        chk("rst_mid_ifBusy", 32'(O_ifBusy), 32'd1);
        chk("rst_mid_dBusy", 32'(O_dBusy), 32'd0);
        @(negedge clk); #1; rst = 1'b0; mem_wait = 0;
        n = 0;
        do begin cyc(); n++; end while (O_ifBusy && n < 60);
        chk("post_rst_latency", 32'(n), 32'd2);
        chk("post_rst_data", O_ifData, 32'hC0DE0020);
        ifEn = 1'b0;
        cyc();

        // Repeated fetch of one word, then a store to it, then fetch again.
        fetch_op(16'h0040, 0, n, ecnt, sa);
        chk("fb1_memE", 32'(ecnt), 32'd1);
        fetch_op(16'h0040, 0, n, ecnt, sa);
        chk("fb2_memE", 32'(ecnt), HAS_BUF ? 32'd0 : 32'd1);
        chk("fb2_latency", 32'(n), HAS_BUF ? 32'd1 : 32'd2);
        chk("fb2_data", O_ifData, 32'hC0DE0010);
        data_op(4'b1111, 16'h0040, 32'hAAAA5555, 0, n, ecnt, we_or, sa);
        fetch_op(16'h0040, 0, n, ecnt, sa);
        chk("fb3_memE", 32'(ecnt), 32'd1);
        chk("fb3_data", O_ifData, 32'hC0DE0010);

        repeat (2) cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
